regfile_xfer_sequencer: RTL

//  Issues register-transfer commands to the 8-entry register file: 7 GP registers plus the PC at index 7.

---
 rtl/regfile_xfer_sequencer_if.sv | 12 +
 rtl/regfile_xfer_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/regfile_xfer_sequencer_if.sv
// Command handshake between the instruction decoder and the register-transfer sequencer.
// The decoder holds cmd_kind/src/dst stable while cmd_valid is high and cmd_ready is low.
interface regfile_xfer_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_kind;
  logic [2:0] cmd_src;
  logic [2:0] cmd_dst;

  modport master (output cmd_valid, output cmd_kind, output cmd_src, output cmd_dst, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_kind, input cmd_src, input cmd_dst, output cmd_ready);
endinterface

// File: rtl/regfile_xfer_sequencer.sv
// Queues register-file transfer commands and sequences the one-hot, active-low OE/load strobes
// and the PC increment/reset lines, all straight from flops.
module regfile_xfer_sequencer #(
  parameter int QDEPTH   = 2,
  parameter int ALU_WAIT = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  regfile_xfer_sequencer_if.slave     cmd,
  output logic [7:0]                  notOE,
  output logic [7:0]                  notLoad,
  output logic                        pcInc,
  output logic                        pcNotReset,
  output logic                        busy,
  output logic                        done
);

  localparam int            AW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(QDEPTH);
  localparam logic [3:0]    WAIT_CNT = 4'(ALU_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2,
    INC   = 2'd3
  } state_t;

  state_t          state_r;
  logic [3:0]      cnt_r;
  logic [2:0]      dst_r;
  logic [6:0]      mem_r [QDEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;

  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic [6:0]      head_s;
  logic            head_kind_s;
  logic [2:0]      head_src_s;
  logic [2:0]      head_dst_s;

  // Active-low one-hot select for an 8-entry register file.
  function automatic logic [7:0] sel_low(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

  assign full_s      = (count_r == FULL_CNT);
  assign empty_s     = (count_r == {(AW+1){1'b0}});
  assign cmd.cmd_ready = pcNotReset & ~full_s;
  assign push_s      = cmd.cmd_valid & cmd.cmd_ready;
  assign pop_s       = (state_r == IDLE) & ~empty_s;
  assign head_s      = mem_r[rd_ptr_r];
  assign head_kind_s = head_s[6];
  assign head_src_s  = head_s[5:3];
  assign head_dst_s  = head_s[2:0];
  assign busy        = (state_r != IDLE) | ~empty_s;

  // PC reset: asserted with reset, released on the first clock edge after it; also gates cmd_ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcNotReset <= 1'b0;
    end else begin
      pcNotReset <= 1'b1;
    end
  end

  // Queue storage; entries are invalidated by pointer reset, so no reset is needed here.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {cmd.cmd_kind, cmd.cmd_src, cmd.cmd_dst};
    end
  end

  // Queue pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Transfer sequencer with registered strobes; done of one command overlaps the next pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      dst_r   <= 3'd0;
      notOE   <= 8'hFF;
      notLoad <= 8'hFF;
      pcInc   <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          notLoad <= 8'hFF;
          pcInc   <= 1'b0;
          done    <= 1'b0;
          notOE   <= 8'hFF;
          if (pop_s) begin
            dst_r <= head_dst_s;
            if (head_kind_s) begin
              pcInc   <= 1'b1;
              state_r <= INC;
            end else if (head_src_s == head_dst_s) begin
              // Self-move is a no-op on the bus: retire immediately without strobes.
              done <= 1'b1;
            end else begin
              notOE   <= sel_low(head_src_s);
              cnt_r   <= WAIT_CNT;
              state_r <= DRIVE;
            end
          end
        end
        DRIVE: begin
          done <= 1'b0;
          if (cnt_r == 4'd1) begin
            notLoad <= sel_low(dst_r);
            state_r <= LOAD;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        LOAD: begin
          notOE   <= 8'hFF;
          notLoad <= 8'hFF;
          done    <= 1'b1;
          state_r <= IDLE;
        end
        INC: begin
          pcInc   <= 1'b0;
          done    <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          notOE   <= 8'hFF;
          notLoad <= 8'hFF;
          pcInc   <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
